// File: rtl/pause_access_sched.sv
// Purpose: merges user/OSD/hiscore pause requests into PAUSE_N (vblank-aligned) and grants hiscore RAM access.
// Latency: pause_n falls 1 cycle after vblank rise; hs_grant 2 cycles after hs_req in HOLD; release to RUN in 1 cycle.
// Backpressure: hs_req is a level handshake; hs_grant is held until hs_req drops, and never while pause_n=1.
module pause_access_sched #(
  parameter int DIM_CYCLES = 480000000,
  parameter int SETTLE     = 4,
  parameter int VB_TIMEOUT = 1000000,
  parameter int CW         = 32
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic user_pause,
  input  logic osd_open,
  input  logic osd_pause_en,
  input  logic hs_req,
  input  logic vblank,
  output logic pause_n,
  output logic hs_grant,
  output logic dim,
  output logic paused
);

  // Settle counter only needs to hold SETTLE-1.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0] VB_LAST     = CW'(VB_TIMEOUT - 1);
  localparam logic [CW-1:0] DIM_MAX     = CW'(DIM_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WAIT_VB,
    ST_SETTLE,
    ST_HOLD,
    ST_GRANT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          user_pause_d;
  logic          vblank_d;
  logic          toggle;
  logic [CW-1:0] vb_cnt;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] dim_cnt;

  logic btn_rise;
  logic vb_rise;
  logic want;
  logic halt_nxt;
  logic hold_nxt;

  assign btn_rise = user_pause & ~user_pause_d;
  assign vb_rise  = vblank & ~vblank_d;
  assign want     = toggle | (osd_open & osd_pause_en) | hs_req;

  // Edge-detect history and the user pause toggle (one flip per button press).
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      user_pause_d <= 1'b0;
      vblank_d     <= 1'b0;
      toggle       <= 1'b0;
    end else begin
      user_pause_d <= user_pause;
      vblank_d     <= vblank;
      toggle       <= toggle ^ btn_rise;
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; requester changes are ignored while settling.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (want) state_nxt = ST_WAIT_VB;
      end
      ST_WAIT_VB: begin
        if (!want)                            state_nxt = ST_RUN;
        else if (vb_rise || vb_cnt == VB_LAST) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // Hiscore access wins over a simultaneous release.
        if (hs_req)     state_nxt = ST_GRANT;
        else if (!want) state_nxt = ST_RUN;
      end
      ST_GRANT: begin
        if (!hs_req) state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Vblank wait timeout and settle countdown.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vb_cnt     <= '0;
      settle_cnt <= '0;
    end else begin
      if (state == ST_WAIT_VB) vb_cnt <= vb_cnt + 1'b1;
      else                     vb_cnt <= '0;

      if (state != ST_SETTLE && state_nxt == ST_SETTLE) settle_cnt <= SETTLE_LAST;
      else if (state == ST_SETTLE && settle_cnt != '0)  settle_cnt <= settle_cnt - 1'b1;
    end
  end

  assign halt_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_HOLD) || (state_nxt == ST_GRANT);
  assign hold_nxt = (state_nxt == ST_HOLD) || (state_nxt == ST_GRANT);

  // Registered outputs; grant rises one cycle into GRANT but drops as soon as GRANT is left,
  // so it can never overlap a running core.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pause_n  <= 1'b1;
      paused   <= 1'b0;
      hs_grant <= 1'b0;
    end else begin
      pause_n  <= ~halt_nxt;
      paused   <= hold_nxt;
      hs_grant <= (state == ST_GRANT) && (state_nxt == ST_GRANT);
    end
  end

  // Dim timer runs only for user pause; clears as soon as the toggle is off.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dim_cnt <= '0;
      dim     <= 1'b0;
    end else if (!toggle) begin
      dim_cnt <= '0;
      dim     <= 1'b0;
    end else begin
      if (dim_cnt < DIM_MAX) dim_cnt <= dim_cnt + 1'b1;
      dim <= (dim_cnt >= DIM_MAX);
    end
  end

endmodule

// File: tb/tb_pause_access_sched.sv
// Bench for pause_access_sched: expected output transitions are queued with their cycle
// when stimulus is driven and matched as the outputs change.
module tb_pause_access_sched;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  logic user_pause = 1'b0;
  logic osd_open = 1'b0;
  logic osd_pause_en = 1'b0;
  logic hs_req = 1'b0;
  logic vblank = 1'b0;
  logic pause_n;
  logic hs_grant;
  logic dim;
  logic paused;

  pause_access_sched #(
    .DIM_CYCLES(100),
    .SETTLE(4),
    .VB_TIMEOUT(1000),
    .CW(32)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .user_pause(user_pause),
    .osd_open(osd_open),
    .osd_pause_en(osd_pause_en),
    .hs_req(hs_req),
    .vblank(vblank),
    .pause_n(pause_n),
    .hs_grant(hs_grant),
    .dim(dim),
    .paused(paused)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int         cyc;
    logic [3:0] val;  // {pause_n, paused, hs_grant, dim}
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en = 1'b0;
  logic [3:0] mon_vec;
  logic [3:0] mon_prev = 4'b1000;
  ev_t mon_ev;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic press(input int n);
    user_pause = 1'b1;
    tick(n);
    user_pause = 1'b0;
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    tick(4);
    vblank = 1'b0;
  endtask

  always @(posedge clk_sys) cyc++;

  // Output monitor: every change must match the head of the scoreboard.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      mon_vec = {pause_n, paused, hs_grant, dim};
      if (hs_grant) chk("grant_while_running", pause_n, 0);
      if (mon_vec != mon_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_change", mon_vec, mon_prev);
        end else begin
          mon_ev = sb.pop_front();
          chk("ev_cycle", cyc, mon_ev.cyc);
          chk("ev_value", mon_vec, mon_ev.val);
        end
        mon_prev = mon_vec;
      end
    end
  end

  int t;

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #20;
    chk("rst_pause_n", pause_n, 1);
    chk("rst_hs_grant", hs_grant, 0);
    chk("rst_dim", dim, 0);
    chk("rst_paused", paused, 0);
    tick(2);
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick(5);

    // 1: idle with periodic vblank, no output may move
    for (int i = 0; i < 4; i++) begin
      tick(496);
      vb_pulse();
    end
    tick(20);

    // 2: short button pulse pauses at the next vblank, second pulse resumes
    t = cyc;
    push(t + 51, 4'b0000);
    push(t + 55, 4'b0100);
    press(3);
    tick(47);
    vb_pulse();
    tick(16);
    push(t + 72, 4'b1000);
    press(3);
    tick(27);

    // 2/5: button held 200 cycles toggles once, dims after the dim period, unpause clears
    t = cyc;
    push(t + 51, 4'b0000);
    push(t + 55, 4'b0100);
    push(t + 102, 4'b0101);
    user_pause = 1'b1;
    tick(50);
    vb_pulse();
    tick(146);
    user_pause = 1'b0;
    tick(50);
    push(t + 252, 4'b1000);
    press(2);
    tick(20);

    // 3: hiscore request from RUN, vblank 20 cycles later
    t = cyc;
    hs_req = 1'b1;
    tick(20);
    push(t + 21, 4'b0000);
    push(t + 25, 4'b0100);
    push(t + 27, 4'b0110);
    vb_pulse();
    tick(16);
    push(t + 41, 4'b0100);
    push(t + 42, 4'b1000);
    hs_req = 1'b0;
    tick(20);

    // 4: vblank stuck low, OSD pause falls back on the timeout
    t = cyc;
    push(t + 1001, 4'b0000);
    push(t + 1005, 4'b0100);
    osd_pause_en = 1'b1;
    osd_open = 1'b1;
    tick(1050);
    push(cyc + 1, 4'b1000);
    osd_open = 1'b0;
    tick(10);
    osd_pause_en = 1'b0;
    osd_open = 1'b1;
    tick(1200);
    osd_open = 1'b0;
    tick(10);

    // 5: user unpause while GRANT takes effect after hs_req drops
    t = cyc;
    press(2);
    tick(8);
    push(t + 11, 4'b0000);
    push(t + 15, 4'b0100);
    vb_pulse();
    tick(6);
    push(t + 22, 4'b0110);
    hs_req = 1'b1;
    tick(10);
    press(2);
    tick(8);
    push(t + 41, 4'b0100);
    push(t + 42, 4'b1000);
    hs_req = 1'b0;
    tick(20);

    // 6: async reset in GRANT with dim active
    t = cyc;
    press(2);
    tick(8);
    push(t + 11, 4'b0000);
    push(t + 15, 4'b0100);
    push(t + 102, 4'b0101);
    push(t + 112, 4'b0111);
    vb_pulse();
    tick(96);
    hs_req = 1'b1;
    tick(20);
    push(cyc + 1, 4'b1000);
    #2 reset_n = 1'b0;
    hs_req = 1'b0;
    #1;
    chk("arst_pause_n", pause_n, 1);
    chk("arst_hs_grant", hs_grant, 0);
    chk("arst_dim", dim, 0);
    chk("arst_paused", paused, 0);
    tick(3);
    reset_n = 1'b1;
    // Toggle must be cleared: nothing pauses even past the vblank timeout
    tick(1100);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
